// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int PC_STEP     = 4;
  localparam int NOP_INSTR   = 0;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular buffer holding prefetched {pc, instr} entries.
module fetch_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count
);
  import fetch_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  // Wraps at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    next_ptr = (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push) tail_r <= next_ptr(tail_r);
      else      tail_r <= tail_r;
      if (pop)  head_r <= next_ptr(head_r);
      else      head_r <= head_r;
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage write port.
  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem_r[tail_r] <= push_data;
  end

  assign head_data = mem_r[head_r];
  assign count     = count_r;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction-fetch front end: PC generation, credit-checked issue, prefetch queue,
// branch redirect flush and sticky halt.
module prefetch_unit #(
  parameter int          PC_W     = 9,
  parameter int          INS_W    = 32,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt,
  output logic             if_valid,
  output logic [PC_W-1:0]  if_pc,
  output logic [INS_W-1:0] if_instr,
  input  logic             id_ready,
  output logic [CNT_W-1:0] fifo_count,
  output logic             halted
);
  import fetch_pkg::*;

  localparam int EW = PC_W + INS_W;

  logic [PC_W-1:0]  fetch_pc_r;
  logic [PC_W-1:0]  inflight_pc_r;
  logic             inflight_r;
  logic             halted_r;

  logic             pop_s;
  logic             push_s;
  logic             clear_s;
  logic             issue_s;
  logic             head_valid_s;
  logic [CNT_W:0]   occ_s;
  logic [CNT_W-1:0] count_s;
  logic [EW-1:0]    head_s;

  assign head_valid_s = (count_s != {CNT_W{1'b0}});
  assign pop_s        = head_valid_s & id_ready & ~redirect_valid;
  assign push_s       = inflight_r & ~redirect_valid & ~reset;
  assign clear_s      = redirect_valid;

  // Counting the pop as a returned credit keeps full throughput even at DEPTH=2.
  assign occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_r} - {{CNT_W{1'b0}}, pop_s};
  assign issue_s = ~reset & ~redirect_valid & ~halted_r & ~halt
                 & (occ_s < (CNT_W + 1)'(DEPTH));

  fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .push_data ({inflight_pc_r, imem_rdata}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  // Fetch PC: reset, then redirect, then sequential advance on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_r <= PC_W'(RESET_PC);
    end else if (redirect_valid) begin
      fetch_pc_r <= {redirect_pc[PC_W-1:2], 2'b00};
    end else if (issue_s) begin
      fetch_pc_r <= fetch_pc_r + PC_W'(PC_STEP);
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // In-flight read tracking and the sticky halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_r    <= 1'b0;
      inflight_pc_r <= PC_W'(RESET_PC);
      halted_r      <= 1'b0;
    end else begin
      inflight_r    <= issue_s;
      inflight_pc_r <= issue_s ? fetch_pc_r : inflight_pc_r;
      halted_r      <= halted_r | halt;
    end
  end

  // Decode-facing outputs present a NOP bubble when the queue is empty.
  always_comb begin
    if_valid = 1'b0;
    if_pc    = {PC_W{1'b0}};
    if_instr = INS_W'(NOP_INSTR);
    if (head_valid_s) begin
      if_valid = 1'b1;
      if_pc    = head_s[EW-1:INS_W];
      if_instr = head_s[INS_W-1:0];
    end else begin
      if_valid = 1'b0;
    end
  end

  assign imem_req   = issue_s;
  assign imem_addr  = fetch_pc_r;
  assign fifo_count = count_s;
  assign halted     = halted_r;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed and randomized bench for prefetch_unit against a queue-based reference model.
module tb_prefetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [8:0]  redirect_pc;
  logic        halt;
  logic        if_valid;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        id_ready;
  logic [2:0]  fifo_count;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  fetch_entry_t mq[$];
  logic [8:0]   m_pc;
  logic [8:0]   m_ipc;
  bit           m_inf;
  bit           m_halted;

  prefetch_unit #(.PC_W(9), .INS_W(32), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .id_ready(id_ready), .fifo_count(fifo_count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {7'h55, a, 7'h2A, a};
  endfunction

  // Synchronous instruction memory; garbage on the bus when no read was issued.
  always @(posedge clk) imem_rdata <= imem_req ? word(imem_addr) : $urandom;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc = 9'd0; m_ipc = 9'd0; m_inf = 1'b0; m_halted = 1'b0;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance the model.
  task automatic step(input bit rst, input bit rdv, input logic [8:0] rpc,
                      input bit hlt, input bit rdy);
    bit m_pop, m_issue;
    fetch_entry_t e;
    reset = rst; redirect_valid = rdv; redirect_pc = rpc; halt = hlt; id_ready = rdy;
    #2;
    m_pop   = (mq.size() != 0) && rdy && !rdv;
    m_issue = !rst && !rdv && !m_halted && !hlt
              && (int'(mq.size()) + int'(m_inf) - int'(m_pop) < DEPTH);
    check("imem_req",   32'(imem_req),   32'(m_issue));
    check("imem_addr",  32'(imem_addr),  32'(m_pc));
    check("if_valid",   32'(if_valid),   32'(mq.size() != 0));
    check("if_pc",      32'(if_pc),      (mq.size() != 0) ? 32'(mq[0].pc) : 32'd0);
    check("if_instr",   if_instr,        (mq.size() != 0) ? mq[0].instr : 32'd0);
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("halted",     32'(halted),     32'(m_halted));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (rdv) begin
      mq.delete();
      m_inf    = 1'b0;
      m_pc     = {rpc[8:2], 2'b00};
      m_halted = m_halted | hlt;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_inf) begin
        e.pc = m_ipc; e.instr = word(m_ipc);
        mq.push_back(e);
      end
      if (m_issue) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 9'd4;
      end
      m_inf    = m_issue;
      m_halted = m_halted | hlt;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 9'd0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 9'd0; halt = 1'b0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Streaming with decode always ready.
    do_reset(2);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // Decode stall fills the queue, then drains in order.
    do_reset(2);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    check("stall_full_count", 32'(fifo_count), 32'd4);
    check("stall_head_pc", 32'(if_pc), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // Redirect with three queued and one in flight, unaligned target.
    do_reset(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    check("pre_redirect_count", 32'(fifo_count), 32'd3);
    step(1'b0, 1'b1, 9'h043, 1'b0, 1'b1);
    check("post_redirect_addr", 32'(imem_addr), 32'h040);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // PC wrap at the top of the 9-bit space, plus back-to-back redirects.
    step(1'b0, 1'b1, 9'h1F8, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 9'h100, 1'b0, 1'b1);
    step(1'b0, 1'b1, 9'h0C6, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // One-cycle halt with two queued; drain, then redirect while halted.
    do_reset(2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 9'd0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);
    check("halt_sticky", 32'(halted), 32'd1);
    step(1'b0, 1'b1, 9'h080, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // Reset with a full queue and a read in flight.
    do_reset(2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b0);
    do_reset(2);
    check("reset_count", 32'(fifo_count), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 9'd0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) == 0, $urandom_range(14) == 0, 9'($urandom),
           $urandom_range(149) == 0, $urandom_range(3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
